// File: rtl/aq_djpeg_dqt_parser.sv
// DQT segment sequencer: parses length and Pq/Tq, streams 64-byte 8-bit quantisation tables into
// the Y/C table RAM, skips unsupported tables and flags malformed segments.
module aq_djpeg_dqt_parser (
  input  logic       clk,
  input  logic       rst,
  input  logic       Start,
  input  logic       InValid,
  input  logic [7:0] InData,
  output logic       InReady,
  output logic       DqtEnable,
  output logic       DqtColor,
  output logic [5:0] DqtCount,
  output logic [7:0] DqtData,
  output logic       Busy,
  output logic       Done,
  output logic       Error
);

  typedef enum logic [2:0] {
    StIdle,
    StLenH,
    StLenL,
    StPqtq,
    StTable,
    StSkip,
    StFin
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  len_h_q, len_h_d;
  logic [15:0] remain_q, remain_d;
  logic [5:0]  idx_q, idx_d;
  logic        err_q, err_d;
  logic        color_q, color_d;
  logic        wr_en_q, wr_en_d;
  logic [5:0]  wr_cnt_q, wr_cnt_d;
  logic [7:0]  wr_data_q, wr_data_d;

  logic        xfer;
  logic [15:0] len_full;
  logic [15:0] remain_dec;

  always_comb begin
    state_d    = state_q;
    len_h_d    = len_h_q;
    remain_d   = remain_q;
    idx_d      = idx_q;
    err_d      = err_q;
    color_d    = color_q;
    wr_en_d    = 1'b0;
    wr_cnt_d   = wr_cnt_q;
    wr_data_d  = wr_data_q;
    len_full   = {len_h_q, InData};
    // Saturating so the byte budget can never underflow.
    remain_dec = (remain_q != 16'd0) ? remain_q - 16'd1 : 16'd0;

    InReady = (state_q == StLenH) || (state_q == StLenL) || (state_q == StPqtq) ||
              (state_q == StTable) || (state_q == StSkip);
    xfer    = InValid & InReady;

    case (state_q)
      StIdle: begin
        if (Start) begin
          err_d   = 1'b0;
          state_d = StLenH;
        end
      end
      StLenH: begin
        if (xfer) begin
          len_h_d = InData;
          state_d = StLenL;
        end
      end
      StLenL: begin
        if (xfer) begin
          if (len_full < 16'd2) begin
            err_d    = 1'b1;
            remain_d = 16'd0;
            state_d  = StFin;
          end else if (len_full == 16'd2) begin
            remain_d = 16'd0;
            state_d  = StFin;
          end else begin
            remain_d = len_full - 16'd2;
            state_d  = StPqtq;
          end
        end
      end
      StPqtq: begin
        if (xfer) begin
          remain_d = remain_dec;
          idx_d    = 6'd0;
          if ((InData[7:4] == 4'd0) && (InData[3:0] <= 4'd1)) begin
            color_d = InData[0];
            // A table header with no payload left is a truncated table.
            if (remain_dec == 16'd0) begin
              err_d   = 1'b1;
              state_d = StFin;
            end else begin
              state_d = StTable;
            end
          end else begin
            err_d   = 1'b1;
            state_d = (remain_dec == 16'd0) ? StFin : StSkip;
          end
        end
      end
      StTable: begin
        if (xfer) begin
          remain_d  = remain_dec;
          wr_en_d   = 1'b1;
          wr_cnt_d  = idx_q;
          wr_data_d = InData;
          idx_d     = idx_q + 6'd1;
          if (idx_q == 6'd63) begin
            state_d = (remain_dec != 16'd0) ? StPqtq : StFin;
          end else if (remain_dec == 16'd0) begin
            err_d   = 1'b1;
            state_d = StFin;
          end
        end
      end
      StSkip: begin
        if (xfer) begin
          remain_d = remain_dec;
          if (remain_dec == 16'd0) begin
            state_d = StFin;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      len_h_q   <= 8'd0;
      remain_q  <= 16'd0;
      idx_q     <= 6'd0;
      err_q     <= 1'b0;
      color_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_cnt_q  <= 6'd0;
      wr_data_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      len_h_q   <= len_h_d;
      remain_q  <= remain_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      color_q   <= color_d;
      wr_en_q   <= wr_en_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign DqtEnable = wr_en_q;
  assign DqtColor  = color_q;
  assign DqtCount  = wr_cnt_q;
  assign DqtData   = wr_data_q;
  assign Busy      = (state_q != StIdle);
  assign Done      = (state_q == StFin);
  assign Error     = err_q;

endmodule

// File: tb/tb_aq_djpeg_dqt_parser.sv
// Randomised bench for the DQT sequencer: segments are scored against a byte-level parse model.
module tb_aq_djpeg_dqt_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Start = 1'b0;
  logic       InValid = 1'b0;
  logic [7:0] InData = 8'd0;
  logic       InReady, DqtEnable, DqtColor, Busy, Done, Error;
  logic [5:0] DqtCount;
  logic [7:0] DqtData;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  stim_q[$];
  logic [14:0] exp_q[$];
  logic [14:0] got_q[$];
  bit          exp_err;
  int          exp_cons;

  always #5 clk = ~clk;

  aq_djpeg_dqt_parser dut (
    .clk       (clk),
    .rst       (rst),
    .Start     (Start),
    .InValid   (InValid),
    .InData    (InData),
    .InReady   (InReady),
    .DqtEnable (DqtEnable),
    .DqtColor  (DqtColor),
    .DqtCount  (DqtCount),
    .DqtData   (DqtData),
    .Busy      (Busy),
    .Done      (Done),
    .Error     (Error)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(InReady), 32'd0);
    check_eq({tag, "_en"}, 32'(DqtEnable), 32'd0);
    check_eq({tag, "_color"}, 32'(DqtColor), 32'd0);
    check_eq({tag, "_count"}, 32'(DqtCount), 32'd0);
    check_eq({tag, "_data"}, 32'(DqtData), 32'd0);
    check_eq({tag, "_busy"}, 32'(Busy), 32'd0);
    check_eq({tag, "_done"}, 32'(Done), 32'd0);
    check_eq({tag, "_error"}, 32'(Error), 32'd0);
  endtask

  // Byte-level parse: a table needs its header plus 64 bytes inside the declared length.
  task automatic model();
    int L, rem, p, n;
    logic [7:0] pq;
    exp_q.delete();
    exp_err = 1'b0;
    L = int'({stim_q[0], stim_q[1]});
    p = 2;
    if (L < 2) begin
      exp_err  = 1'b1;
      exp_cons = 2;
      return;
    end
    rem = L - 2;
    while (rem > 0) begin
      pq = stim_q[p];
      p++;
      rem--;
      if (pq[7:4] != 4'd0 || pq[3:0] > 4'd1) begin
        exp_err = 1'b1;
        p += rem;
        rem = 0;
      end else begin
        n = (rem < 64) ? rem : 64;
        for (int i = 0; i < n; i++) exp_q.push_back({pq[0], 6'(i), stim_q[p + i]});
        p += n;
        rem -= n;
        if (n < 64) exp_err = 1'b1;
      end
    end
    exp_cons = p;
  endtask

  task automatic push_junk();
    for (int i = 0; i < 4; i++) stim_q.push_back(8'($urandom));
  endtask

  task automatic run_segment(input string tag, input int valid_pct, input bit noise_start,
                             input int abort_after);
    int  p = 0;
    int  done_cnt = 0;
    int  cyc = 0;
    bit  xfer;
    bit  aborted = 1'b0;
    got_q.delete();
    model();
    Start = 1'b1;
    InValid = 1'b0;
    @(posedge clk); #1;
    Start = 1'b0;
    check_eq({tag, "_busy_start"}, 32'(Busy), 32'd1);
    check_eq({tag, "_err_clear"}, 32'(Error), 32'd0);
    while (done_cnt == 0 && cyc < 3000 && !aborted) begin
      cyc++;
      InValid = ($urandom_range(99) < valid_pct) && (p < stim_q.size());
      InData  = (p < stim_q.size()) ? stim_q[p] : 8'($urandom);
      Start   = noise_start && Busy && !Done && ($urandom_range(7) == 0);
      @(negedge clk);
      if (DqtEnable) got_q.push_back({DqtColor, DqtCount, DqtData});
      if (Done) done_cnt++;
      check_eq({tag, "_inready"}, 32'(InReady), 32'(Busy & ~Done));
      xfer = InValid & InReady;
      if (abort_after >= 0 && got_q.size() > abort_after) begin
        #2 rst = 1'b0;
        #1 check_reset_outputs({tag, "_async_rst"});
        @(posedge clk); #2 rst = 1'b1;
        aborted = 1'b1;
      end
      @(posedge clk); #1;
      if (xfer && !aborted) p++;
    end
    Start = 1'b0;
    if (aborted) begin
      InValid = 1'b0;
      return;
    end
    check_eq({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
    for (int k = 0; k < 3; k++) begin
      InValid = 1'b1;
      @(negedge clk);
      check_eq({tag, "_idle_en"}, 32'(DqtEnable), 32'd0);
      check_eq({tag, "_idle_busy"}, 32'(Busy), 32'd0);
      check_eq({tag, "_idle_ready"}, 32'(InReady), 32'd0);
      @(posedge clk); #1;
    end
    InValid = 1'b0;
    check_eq({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check_eq({tag, "_write"}, 32'(got_q[i]), 32'(exp_q[i]));
      if (got_q[i] !== exp_q[i]) break;
    end
    check_eq({tag, "_error"}, 32'(Error), 32'(exp_err));
    check_eq({tag, "_consumed"}, 32'(p), 32'(exp_cons));
  endtask

  task automatic build_single_y();
    stim_q.delete();
    stim_q.push_back(8'h00); stim_q.push_back(8'h43); stim_q.push_back(8'h00);
    for (int v = 1; v <= 64; v++) stim_q.push_back(8'(v));
    push_junk();
  endtask

  task automatic build_random();
    int L;
    logic [7:0] hdrs[5];
    hdrs[0] = 8'h00; hdrs[1] = 8'h01; hdrs[2] = 8'h11; hdrs[3] = 8'h02; hdrs[4] = 8'h10;
    case ($urandom_range(3))
      0:       L = 16'h0043;
      1:       L = 16'h0084;
      2:       L = 16'h0085;
      default: L = $urandom_range(0, 200);
    endcase
    stim_q.delete();
    stim_q.push_back(8'(L >> 8));
    stim_q.push_back(8'(L));
    for (int k = 0; k < L - 2; k++) begin
      if (k % 65 == 0) stim_q.push_back(hdrs[$urandom_range(4)]);
      else stim_q.push_back(8'($urandom));
    end
    push_junk();
  endtask

  initial begin
    #3;
    check_reset_outputs("reset");
    #10 rst = 1'b1;
    @(posedge clk); #1;

    build_single_y();
    run_segment("single_y", 100, 1'b0, -1);

    stim_q.delete();
    stim_q.push_back(8'h00); stim_q.push_back(8'h84);
    stim_q.push_back(8'h00);
    for (int i = 0; i < 64; i++) stim_q.push_back(8'h10);
    stim_q.push_back(8'h01);
    for (int i = 0; i < 64; i++) stim_q.push_back(8'h20);
    push_junk();
    run_segment("two_tables", 100, 1'b0, -1);

    build_single_y();
    run_segment("backpressure", 50, 1'b1, -1);

    stim_q.delete();
    stim_q.push_back(8'h00); stim_q.push_back(8'h43); stim_q.push_back(8'h12);
    for (int i = 0; i < 64; i++) stim_q.push_back(8'($urandom));
    push_junk();
    run_segment("unsupported", 70, 1'b0, -1);
    check_eq("unsupported_sticky", 32'(Error), 32'd1);

    build_single_y();
    run_segment("after_unsup", 100, 1'b0, -1);

    stim_q.delete();
    stim_q.push_back(8'h00); stim_q.push_back(8'h20); stim_q.push_back(8'h00);
    for (int i = 0; i < 30; i++) stim_q.push_back(8'($urandom));
    push_junk();
    run_segment("short_len", 80, 1'b0, -1);

    stim_q.delete();
    stim_q.push_back(8'h00); stim_q.push_back(8'h01);
    push_junk();
    run_segment("len_one", 100, 1'b0, -1);

    build_single_y();
    run_segment("abort", 100, 1'b0, 10);
    build_single_y();
    run_segment("post_abort", 100, 1'b0, -1);

    for (int t = 0; t < 12; t++) begin
      build_random();
      run_segment("random", $urandom_range(30, 100), 1'b1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
